// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, byte width and synchronizer default for the SPI receiver.
package spi_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int BYTE_W          = 8;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: receive FIFO of {dc, byte} entries; DEPTH is a power of two >= 2.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BYTE_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/spi_rx_ip.sv
// spi_rx_ip: SPI mode-0 byte receiver with dc flag, sticky overrun and output storage.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead of a single holding register.
module spi_rx_ip
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              cs_i,
    input  logic              dc_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic [BYTE_W-1:0] data_out_o,
    output logic              dc_out_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic              busy_o
);
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  smp_q;
    logic                        scl_prev_q;
    logic [SYNC_STAGES:0]        warm_q;
    logic                        armed_q;
    state_t                      state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [BYTE_W-1:0]           shift_q, shift_d;
    logic                        done_q, done_d;
    logic                        dc_lat_q, dc_lat_d;
    logic                        ovr_q;
    logic                        full, pop, push_ok;
    logic cs_s, dc_s, sda_s, rise;
    assign {cs_s, dc_s} = smp_q[3:2];
    assign sda_s        = smp_q[0];
    assign rise         = smp_q[1] & ~scl_prev_q;
    assign busy_o       = state_q == SHIFT;
    // Arming needs cs seen low once the pipeline holds real pin samples, so a cs
    // held high across reset cannot start a transfer mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            smp_q      <= '0;
            scl_prev_q <= 1'b0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], {cs_i, dc_i, scl_i, sda_i}};
            smp_q      <= sync_q[SYNC_STAGES-1];
            scl_prev_q <= smp_q[1];
            warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            armed_q    <= armed_q | (warm_q[SYNC_STAGES] & ~cs_s);
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        dc_lat_d = dc_lat_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (enable_i && cs_s && armed_q) state_d = SHIFT;
        end else if (!enable_i || !cs_s) begin
            state_d = IDLE;
        end else if (rise) begin
            shift_d = {shift_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                dc_lat_d = dc_s;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            done_q   <= 1'b0;
            dc_lat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            dc_lat_q <= dc_lat_d;
        end
    end
    // A completion may take the slot being consumed in the same cycle.
    assign pop     = data_valid_o & data_ready_i;
    assign push_ok = done_q & (~full | pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 1'b0;
        else        ovr_q <= (done_q & full & ~pop) | (ovr_q & ~clr_overrun_i);
    end
    assign overrun_o = ovr_q;
`ifdef SPI_RX_FIFO_EN
    logic              empty;
    logic [BYTE_W:0]   rdata;
    spi_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i ({dc_lat_q, shift_q}),
        .rdata_o (rdata),
        .empty_o (empty),
        .full_o  (full)
    );
    assign data_valid_o           = ~empty;
    assign {dc_out_o, data_out_o} = rdata;
`else
    logic [BYTE_W:0] hold_q;
    logic            hval_q;
    logic            unused_cfg;
    assign unused_cfg = ^FIFO_DEPTH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hval_q <= 1'b0;
        end else if (push_ok) begin
            hold_q <= {dc_lat_q, shift_q};
            hval_q <= 1'b1;
        end else if (pop) begin
            hval_q <= 1'b0;
        end
    end
    assign full                   = hval_q;
    assign data_valid_o           = hval_q;
    assign {dc_out_o, data_out_o} = hold_q;
`endif
endmodule
